// File: rtl/stream_pkg.sv
// Shared types for valid/ready stream blocks: skid-buffer state and
// occupancy encoding.
package stream_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } stream_skid_state_t;

    typedef logic [1:0] occupancy_t;

    function automatic occupancy_t occupancy_of(input stream_skid_state_t state);
        case (state)
            ONE:     occupancy_of = 2'd1;
            FULL:    occupancy_of = 2'd2;
            default: occupancy_of = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/stream_skid_buffer.sv
// Two-entry registered skid buffer for a valid/ready stream; absorbs one
// extra transfer when downstream drops ready, gated by enable_in.
module stream_skid_buffer
    import stream_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable_in,
    input  logic                  valid_input,
    output logic                  ready_input,
    input  logic [DATA_WIDTH-1:0] data_input,
    output logic                  valid_output,
    input  logic                  ready_output,
    output logic [DATA_WIDTH-1:0] data_output,
    output logic [1:0]            occupancy
);

    stream_skid_state_t    state_q, state_d;
    logic [DATA_WIDTH-1:0] main_q, main_d;
    logic [DATA_WIDTH-1:0] skid_q, skid_d;
    logic                  in_xfer;
    logic                  out_xfer;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        ready_input  = enable_in && (state_q != FULL);
        // Masking valid during reset guarantees no entry leaves in the cycle it is discarded.
        valid_output = enable_in && !rst && (state_q != EMPTY);
        in_xfer      = valid_input && ready_input;
        out_xfer     = valid_output && ready_output;

        case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    state_d = ONE;
                    main_d  = data_input;
                end
            end
            ONE: begin
                if (in_xfer && out_xfer) begin
                    main_d = data_input;
                end else if (in_xfer) begin
                    state_d = FULL;
                    skid_d  = data_input;
                end else if (out_xfer) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_xfer) begin
                    state_d = ONE;
                    main_d  = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    assign data_output = main_q;
    assign occupancy   = occupancy_of(state_q);

endmodule
